// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and the service FSM state type for the
// interrupt pending front-end and its priority encoder.
package irq_pkg;

    localparam int N = 8;   // number of request lines
    localparam int W = 3;   // code width, log2(N)

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/priority_encoder.sv
// priority_encoder: combinational 8-to-3 encoder, highest set bit wins.
// Ports:
//   in    - request vector
//   code  - index of highest set bit (0 when idle)
//   idle  - 1 when in is all zero
module priority_encoder
    import irq_pkg::*;
(
    input  logic [N-1:0] in,
    output logic [W-1:0] code,
    output logic         idle
);

    always_comb begin
        code = '0;
        idle = 1'b1;
        // Ascending scan: the last hit is the highest index.
        for (int i = 0; i < N; i++) begin
            if (in[i]) begin
                code = W'(i);
                idle = 1'b0;
            end
        end
    end

endmodule

// File: rtl/req_edge_detect.sv
// req_edge_detect: registers the raw request lines and flags 0->1 transitions.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   req       - raw level request lines
//   rise      - one-cycle pulse per line on a rising edge of req
module req_edge_detect
    import irq_pkg::*;
#(
    parameter int NL = N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NL-1:0] req,
    output logic [NL-1:0] rise
);

    logic [NL-1:0] req_q;

    // req_q resets to 0, so a line held high through reset shows up as a
    // rise on the first cycle after reset releases.
    always_ff @(posedge clk) begin
        if (rst) req_q <= '0;
        else     req_q <= req;
    end

    genvar i;
    generate
        for (i = 0; i < NL; i++) begin : g_lane
            assign rise[i] = req[i] & ~req_q[i];
        end
    endgenerate

endmodule

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: captures request rising edges into a pending register,
// presents pending & mask to an external priority encoder, and issues the
// encoder's choice one at a time over a valid/ack handshake.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req        - raw request lines (level)
//   mask       - 1 = line enabled for service
//   enc_in     - to encoder, pending & mask (combinational)
//   enc_out    - encoder code
//   enc_idle   - encoder idle flag
//   irq_valid  - service request valid
//   irq_id     - index being serviced, stable while irq_valid
//   irq_ack    - consumer accepts irq_id
//   pending    - pending register
//   ovr        - sticky overrun flags, cleared when the line is acked
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int N_P = N,
    parameter int W_P = W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N_P-1:0] req,
    input  logic [N_P-1:0] mask,
    output logic [N_P-1:0] enc_in,
    input  logic [W_P-1:0] enc_out,
    input  logic           enc_idle,
    output logic           irq_valid,
    output logic [W_P-1:0] irq_id,
    input  logic           irq_ack,
    output logic [N_P-1:0] pending,
    output logic [N_P-1:0] ovr
);

    state_t         state;
    logic [N_P-1:0] rise;
    logic [N_P-1:0] clr;

    req_edge_detect #(.NL(N_P)) u_edge (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .rise (rise)
    );

    assign enc_in = pending & mask;

    // Ack only counts while serving; in IDLE it is ignored.
    assign clr = (state == SERVE && irq_ack)
               ? ({{(N_P-1){1'b0}}, 1'b1} << irq_id) : '0;

    // A rise wins over a same-cycle clear so the new event is never lost.
    // Overrun needs the bit to stay pending, so a rise that coincides with
    // its own ack is a fresh event, not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            ovr     <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
            ovr     <= (ovr & ~clr) | (rise & pending & ~clr);
        end
    end

    // irq_id is frozen in SERVE; mask or pending changes cannot withdraw it.
    // Returning to IDLE for one cycle gives the guaranteed low gap and lets
    // the encoder see the cleared pending bit before the next pick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!enc_idle) begin
                        irq_id    <= enc_out;
                        irq_valid <= 1'b1;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (irq_ack) begin
                        irq_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;
    import irq_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, mask, enc_in, pending, ovr;
    logic [W-1:0] enc_out, irq_id;
    logic         enc_idle, irq_valid, irq_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    irq_pending_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .enc_in(enc_in), .enc_out(enc_out), .enc_idle(enc_idle),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack),
        .pending(pending), .ovr(ovr)
    );

    priority_encoder u_enc (
        .in(enc_in), .code(enc_out), .idle(enc_idle)
    );

    // Reference model: per-line flags plus "who is being served".
    bit m_pend [N];
    bit m_ovr  [N];
    bit m_prev [N];
    bit m_busy;
    int m_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] pack(input bit a [N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    // One clock: drive inputs, advance the model by the rules, compare after the edge.
    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] m,
                       input logic a, input logic rs);
        bit n_pend [N];
        bit n_ovr  [N];
        bit n_busy;
        int n_id;
        bit got_ack;
        @(negedge clk);
        req = r; mask = m; irq_ack = a; rst = rs;
        n_busy = m_busy;
        n_id   = m_id;
        if (rs) begin
            for (int i = 0; i < N; i++) begin n_pend[i] = 0; n_ovr[i] = 0; end
            n_busy = 0; n_id = 0;
        end else begin
            got_ack = m_busy && a;
            for (int i = 0; i < N; i++) begin
                bit rise_i, clr_i;
                rise_i = r[i] && !m_prev[i];
                clr_i  = got_ack && (i == m_id);
                n_pend[i] = rise_i ? 1'b1 : (clr_i ? 1'b0 : m_pend[i]);
                n_ovr[i]  = (rise_i && m_pend[i] && !clr_i) ? 1'b1
                          : (clr_i ? 1'b0 : m_ovr[i]);
            end
            if (m_busy) begin
                if (a) n_busy = 0;
            end else begin
                // highest pending and enabled line gets served next
                for (int i = 0; i < N; i++)
                    if (m_pend[i] && m[i]) begin n_busy = 1; n_id = i; end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = n_pend[i];
            m_ovr[i]  = n_ovr[i];
            m_prev[i] = rs ? 1'b0 : r[i];
        end
        m_busy = n_busy;
        m_id   = n_id;
        chk("pending",   pending,   pack(m_pend));
        chk("ovr",       ovr,       pack(m_ovr));
        chk("enc_in",    enc_in,    pack(m_pend) & mask);
        chk("irq_valid", irq_valid, m_busy);
        if (m_busy) chk("irq_id", irq_id, m_id);
    endtask

    initial begin
        req = '0; mask = '0; irq_ack = 0; rst = 1;
        for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_ovr[i] = 0; m_prev[i] = 0; end
        m_busy = 0; m_id = 0;

        // reset state, with a line held high through reset
        cyc(8'h00, 8'hFF, 0, 1);
        cyc(8'h01, 8'hFF, 0, 1);
        chk("rst_id", irq_id, 0);

        // single request: bit 2, acked, held high so no re-service
        cyc(8'h00, 8'hFF, 0, 0);
        cyc(8'h04, 8'hFF, 0, 0);
        chk("single_pend", pending, 8'h04);
        cyc(8'h04, 8'hFF, 0, 0);
        chk("single_id", {irq_valid, irq_id}, {1'b1, 3'd2});
        cyc(8'h04, 8'hFF, 1, 0);
        chk("single_ack", {irq_valid, pending}, 9'h0);
        repeat (3) cyc(8'h04, 8'hFF, 0, 0);

        // priority 6,5,1 with immediate acks
        cyc(8'h62, 8'hFF, 0, 0);
        repeat (8) cyc(8'h62, 8'hFF, irq_valid, 0);
        chk("prio_empty", pending, 8'h00);

        // masking: bit 7 waits until unmasked
        cyc(8'h00, 8'h7F, 0, 0);
        cyc(8'h88, 8'h7F, 0, 0);
        cyc(8'h88, 8'h7F, 0, 0);
        chk("mask_id3", irq_id, 3'd3);
        cyc(8'h88, 8'h7F, 1, 0);
        cyc(8'h88, 8'h7F, 0, 0);
        chk("mask_idle", enc_idle, 1'b1);
        cyc(8'h88, 8'hFF, 0, 0);
        chk("mask_id7", {irq_valid, irq_id}, {1'b1, 3'd7});
        cyc(8'h00, 8'hFF, 1, 0);

        // overrun, then ack coinciding with a new rise on bit 4
        cyc(8'h10, 8'h00, 0, 0);
        cyc(8'h00, 8'h00, 0, 0);
        cyc(8'h10, 8'h00, 0, 0);
        chk("ovr4", ovr[4], 1'b1);
        cyc(8'h00, 8'hFF, 0, 0);
        cyc(8'h10, 8'hFF, 1, 0);
        chk("setwins", {pending[4], ovr[4]}, 2'b10);
        cyc(8'h10, 8'hFF, 0, 0);
        chk("reserve4", {irq_valid, irq_id}, {1'b1, 3'd4});
        cyc(8'h00, 8'hFF, 1, 0);
        cyc(8'h00, 8'hFF, 0, 0);

        // randomized traffic, including mid-service resets
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] r, m;
            r = N'($urandom) & N'($urandom);
            m = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
            cyc(r, m, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
